frame_sequencer: RTL
====================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter PWM_WIDTH, default 8, width of the brightness bus, matching the display scanner.
REQ-002 SHALL have parameter FADE_DIV, default 50000, clocks per fade step (minimum 1).
REQ-003 SHALL have port clk  input  1  system clock (50 MHz); the single clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_valid  input  1  row-write request.
REQ-006 SHALL have port wr_ready  output  1  block can accept a write.
REQ-007 SHALL have port wr_addr  input  3  row number being written.
REQ-008 SHALL have port wr_data  input  8  row pixels; 1 = lit.
REQ-009 SHALL have port wr_last  input  1  this write completes the back frame.
REQ-010 SHALL have port row_idx  input  3  current scan row from the display scanner.
REQ-011 SHALL have port frame_data  output  8  pixel row for the scanner.
REQ-012 SHALL have port bright_target  input  PWM_WIDTH  requested brightness.
REQ-013 SHALL have port brightness  output  PWM_WIDTH  brightness to the scanner.
REQ-014 SHALL have port swap_pending  output  1  back frame committed, awaiting swap.

Function
REQ-015 SHALL hold two 8x8-bit banks; disp_sel (0/1) selects the displayed bank, and the other bank is the back bank.
REQ-016 SHALL accept a write on the clk edge where wr_valid && wr_ready, storing wr_data into back_bank[wr_addr].
REQ-017 SHALL drive wr_ready = !swap_pending, with wr_valid ignored when wr_ready=0.
REQ-018 SHALL set swap_pending on the edge of an accepted write carrying wr_last=1; the write data is stored on the same edge.
REQ-019 SHALL detect frame wrap as a registered row_idx_prev==7 with current row_idx==0.
REQ-020 SHALL, on a wrap with swap_pending already 1, toggle disp_sel and clear swap_pending on that edge.
REQ-021 SHALL NOT swap on a wrap that coincides with the wr_last acceptance, because swap_pending was not yet set; the swap then occurs at the next wrap.
REQ-022 SHALL register frame_data <= bank[disp_sel_next][row_idx] with 1-cycle latency; the cycle after a swap edge SHALL already show the new bank.
REQ-023 SHALL read row_idx values other than 7->0 without side effects; non-sequential jumps SHALL NOT trigger a swap.
REQ-024 SHALL, with fade enabled, run a ramp FSM with states IDLE/UP/DOWN: IDLE->UP if target>brightness, IDLE->DOWN if target<brightness, UP/DOWN->IDLE when brightness==target.
REQ-025 SHALL run a step timer that counts 0..FADE_DIV-1 only in UP/DOWN; on wrap it steps brightness +1 (UP) or -1 (DOWN); the timer clears on entering IDLE.
REQ-026 SHALL re-evaluate direction every cycle on a target change mid-ramp, switching UP<->DOWN without resetting the timer.
REQ-027 SHALL saturate brightness: no wrap past 0 or 2^PWM_WIDTH-1.

Reset
REQ-028 SHALL, while rst=1, force: both banks 0, disp_sel=0, row_idx_prev=0, frame_data=0, brightness=0, swap_pending=0, wr_ready=0, FSM=IDLE, timer=0.
REQ-029 SHALL assert wr_ready on the first clk edge after rst deasserts.
REQ-030 SHALL, on reset mid-operation, discard any pending swap and the partially written back frame.

Configuration
REQ-031 SHALL use macro FRAME_SEQUENCER_FADE_EN: when defined, the ramp FSM and timer of REQ-024..027 are built.
REQ-032 SHALL, when FRAME_SEQUENCER_FADE_EN is undefined, register brightness <= bright_target with 1-cycle latency and build no FSM or timer.

Verification
REQ-033 SHALL cover: reset released, row_idx stepped 0..7 -> frame_data=0x00 every row, wr_ready=1 one cycle after release, brightness=0.
REQ-034 SHALL cover: write rows 0..7 = 0x01,0x02..0x80 with wr_last on row 7, then a 7->0 wrap -> swap_pending 1 then 0, and row_idx=3 yields frame_data=0x08 one cycle later.
REQ-035 SHALL cover: wr_valid held while swap_pending=1 -> no bank change, wr_ready=0 until the swap edge.
REQ-036 SHALL cover: wr_last accepted on the same edge as a 7->0 wrap -> no swap that frame; swap on the following wrap.
REQ-037 SHALL cover (FADE_EN, FADE_DIV=4): target 0->3 -> brightness 1,2,3 at 4-cycle intervals then IDLE; target 3->0 then 2 mid-ramp -> DOWN turns to UP and settles at 2.
REQ-038 SHALL cover: rst pulsed mid-fade with swap_pending=1 -> all outputs at reset values immediately and the back frame is lost.

Source files
------------

// File: rtl/frame_sequencer.sv
// frame_sequencer: double-buffered 8x8 frame store with swap on frame wrap.
// Optional brightness fade ramp built when FRAME_SEQUENCER_FADE_EN is defined.
module frame_sequencer #(
  parameter int PWM_WIDTH = 8,
  parameter int FADE_DIV  = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [2:0]           wr_addr,
  input  logic [7:0]           wr_data,
  input  logic                 wr_last,
  input  logic [2:0]           row_idx,
  output logic [7:0]           frame_data,
  input  logic [PWM_WIDTH-1:0] bright_target,
  output logic [PWM_WIDTH-1:0] brightness,
  output logic                 swap_pending
);

  logic       ready_q;
  logic       swap_q;
  logic       disp_sel;
  logic       back_sel;
  logic       disp_next;
  logic [2:0] row_prev;
  logic       wr_fire;
  logic       wrap;
  logic       swap_now;
  logic [7:0] bank [0:1][0:7];

  assign back_sel     = ~disp_sel;
  assign wr_ready     = ready_q && !swap_q;
  assign swap_pending = swap_q;
  assign wr_fire      = wr_valid && wr_ready;
  assign wrap         = (row_prev == 3'd7) && (row_idx == 3'd0);
  assign swap_now     = wrap && swap_q;
  assign disp_next    = disp_sel ^ swap_now;

  // Ready comes up one edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  // Track the previous scan row to spot the 7->0 frame wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) row_prev <= 3'd0;
    else     row_prev <= row_idx;
  end

  // Commit/swap handshake: wr_last arms a swap, the next wrap performs it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_q   <= 1'b0;
      disp_sel <= 1'b0;
    end else if (swap_now) begin
      swap_q   <= 1'b0;
      disp_sel <= ~disp_sel;
    end else if (wr_fire && wr_last) begin
      swap_q   <= 1'b1;
    end
  end

  // Row writes always land in the bank that is not on display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 8; r++)
          bank[b][r] <= 8'h00;
    end else if (wr_fire) begin
      bank[back_sel][wr_addr] <= wr_data;
    end
  end

  // Read through the post-swap select so the new bank shows immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_data <= 8'h00;
    else     frame_data <= bank[disp_next][row_idx];
  end

`ifdef FRAME_SEQUENCER_FADE_EN

  localparam int TW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [TW-1:0] T_MAX = TW'(FADE_DIV - 1);
  localparam logic [PWM_WIDTH-1:0] B_MAX = {PWM_WIDTH{1'b1}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  logic [1:0]           state;
  logic [TW-1:0]        timer;
  logic [PWM_WIDTH-1:0] bright_q;
  logic                 go_up;
  logic                 go_down;

  assign go_up      = bright_target > bright_q;
  assign go_down    = bright_target < bright_q;
  assign brightness = bright_q;

  // Ramp FSM: step one level toward the target per timer wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      timer    <= '0;
      bright_q <= '0;
    end else begin
      unique case (state)
        ST_UP, ST_DOWN: begin
          if (!go_up && !go_down) begin
            state <= ST_IDLE;
            timer <= '0;
          end else begin
            state <= go_up ? ST_UP : ST_DOWN;
            if (timer == T_MAX) begin
              timer <= '0;
              if (go_up && bright_q != B_MAX)
                bright_q <= bright_q + 1'b1;
              else if (go_down && bright_q != '0)
                bright_q <= bright_q - 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        default: begin
          timer <= '0;
          if (go_up)        state <= ST_UP;
          else if (go_down) state <= ST_DOWN;
          else              state <= ST_IDLE;
        end
      endcase
    end
  end

`else

  logic fade_div_unused;
  assign fade_div_unused = (FADE_DIV > 0);

  // Without the ramp, brightness simply follows the target one cycle late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) brightness <= '0;
    else     brightness <= bright_target;
  end

`endif

endmodule
